// File: rtl/muldiv_pkg.sv
// muldiv_pkg: ALU control codes, MIPS mul/div op encodings and sequencer states.
package muldiv_pkg;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SRL  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABS_A,
    S_ABS_B,
    S_ITER,
    S_FIX_LO,
    S_FIX_HI,
    S_DONE
  } state_t;
endpackage

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: MULT/MULTU/DIV/DIVU on a shared external ALU, one ALU op per cycle,
// sign-magnitude: abs both operands, 32 shift-add / restoring-divide steps, then sign fix.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int ITERS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        alu_req,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero
);
  localparam int CW = $clog2(ITERS);

  state_t          r_state;
  logic            r_div;
  logic            r_sgn_a;
  logic            r_sgn_b;
  logic [31:0]     r_a;
  logic [31:0]     r_b;
  logic [31:0]     r_hi;
  logic [31:0]     r_lo;
  logic [CW-1:0]   r_cnt;
  logic            r_dbz;

  logic [31:0]     w_s;
  logic            w_m;
  logic            w_borrow;
  logic            w_carry;
  logic            w_neg_q;
  logic            w_dbz;

  assign w_s      = {r_hi[30:0], r_lo[31]};
  assign w_m      = r_hi[31];
  assign w_borrow = w_s < r_b;
  assign w_carry  = alu_result < alu_a;
  assign w_neg_q  = r_sgn_a ^ r_sgn_b;
  assign w_dbz    = op[1] & (rt_val == '0);

  assign start_ready = (r_state == S_IDLE) | (r_state == S_DONE);
  assign busy        = ~start_ready;
  assign alu_req     = busy;
  assign done        = r_state == S_DONE;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_by_zero = r_dbz;

  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = ALU_ADD;
    case (r_state)
      S_ABS_A: begin
        alu_ctrl = r_sgn_a ? ALU_SUB : ALU_ADD;
        alu_a    = r_sgn_a ? '0 : r_a;
        alu_b    = r_sgn_a ? r_a : '0;
      end
      S_ABS_B: begin
        alu_ctrl = r_sgn_b ? ALU_SUB : ALU_ADD;
        alu_a    = r_sgn_b ? '0 : r_b;
        alu_b    = r_sgn_b ? r_b : '0;
      end
      S_ITER: begin
        alu_ctrl = r_div ? ALU_SUB : ALU_ADD;
        alu_a    = r_div ? w_s : r_hi;
        alu_b    = r_div ? r_b : (r_lo[0] ? r_a : '0);
      end
      S_FIX_LO: begin
        alu_ctrl = w_neg_q ? ALU_SUB : ALU_ADD;
        alu_a    = w_neg_q ? '0 : r_lo;
        alu_b    = w_neg_q ? r_lo : '0;
      end
      S_FIX_HI: begin
        // LO is already negated here; it is zero exactly when the pre-fix LO was zero
        alu_ctrl = (r_div & r_sgn_a) ? ALU_SUB : ALU_ADD;
        alu_a    = r_div ? (r_sgn_a ? '0 : r_hi) : (w_neg_q ? ~r_hi : r_hi);
        alu_b    = r_div ? (r_sgn_a ? r_hi : '0) : {31'b0, w_neg_q & (r_lo == '0)};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_div   <= 1'b0;
      r_sgn_a <= 1'b0;
      r_sgn_b <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_state <= S_IDLE;
          if (start_valid) begin
            r_div   <= op[1];
            r_sgn_a <= ~op[0] & rs_val[31];
            r_sgn_b <= ~op[0] & rt_val[31];
            r_a     <= rs_val;
            r_b     <= rt_val;
            r_dbz   <= w_dbz;
            r_state <= w_dbz ? S_DONE : S_ABS_A;
            if (w_dbz) begin
              r_hi <= rs_val;
              r_lo <= '1;
            end
          end
        end
        S_ABS_A: begin
          r_a     <= alu_result;
          r_state <= S_ABS_B;
        end
        S_ABS_B: begin
          r_b     <= alu_result;
          r_hi    <= '0;
          r_lo    <= r_div ? r_a : alu_result;
          r_cnt   <= '0;
          r_state <= S_ITER;
        end
        S_ITER: begin
          if (r_div) begin
            r_hi <= (w_m | ~w_borrow) ? alu_result : w_s;
            r_lo <= {r_lo[30:0], w_m | ~w_borrow};
          end else begin
            {r_hi, r_lo} <= {w_carry, alu_result, r_lo[31:1]};
          end
          r_cnt   <= r_cnt + 1'b1;
          r_state <= (r_cnt == CW'(ITERS - 1)) ? S_FIX_LO : S_ITER;
        end
        S_FIX_LO: begin
          r_lo    <= alu_result;
          r_state <= S_FIX_HI;
        end
        S_FIX_HI: begin
          r_hi    <= alu_result;
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle controller that executes MIPS MULT, MULTU, DIV and DIVU by sequencing the shared 32-bit ALU, one ALU operation per cycle. It holds the HI/LO result registers and presents a valid/ready start handshake to the execute stage. The shift-add and restoring-division iterations run through the ALU's add (4'b0010) and subtract (4'b0110) functions. Carry and borrow are derived locally, so no extra ALU cycles are spent on compares.

## Interface
Parameters:
- ITERS, 32, iteration count; equals the operand width and is fixed at 32.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- start_valid  in  1  operation request
- start_ready  out  1  block can accept a request
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs_val  in  32  multiplicand / dividend
- rt_val  in  32  multiplier / divisor
- alu_req  out  1  block drives the ALU this cycle
- alu_a  out  32  ALU first operand
- alu_b  out  32  ALU second operand
- alu_ctrl  out  4  ALU control code
- alu_result  in  32  combinational ALU result for alu_a/alu_b/alu_ctrl
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; hi/lo valid
- hi  out  32  HI register
- lo  out  32  LO register
- div_by_zero  out  1  set with done when a DIV/DIVU had rt_val==0; cleared on next accept

## Operation
- Accept: start_valid & start_ready at a rising edge. The block latches op, the operand signs and the operands.
- start_ready = (state==IDLE) | (state==DONE). A new request may be accepted in the DONE cycle.
- States and sequence: IDLE -> ABS_A -> ABS_B -> ITER (32 cycles, counter 0..31) -> FIX_LO -> FIX_HI -> DONE -> IDLE.
- Divide-by-zero goes IDLE -> DONE directly and sets HI=rs_val, LO=32'hFFFF_FFFF, div_by_zero=1.
- ABS_A / ABS_B:
  - For a signed op with a negative operand, issue sub with a=0, b=x and store the result as the magnitude.
  - Otherwise issue add with a=x, b=0.
  - 0x8000_0000 yields magnitude 0x8000_0000, treated as unsigned.
- ITER, multiply (HI=0, LO=|rt| at start):
  - Issue add with a=HI, b=(LO[0] ? |rs| : 0).
  - carry = (alu_result < alu_a), unsigned.
  - {HI,LO} <= {carry, alu_result, LO[31:1]}.
- ITER, divide (HI=0, LO=|rs| at start):
  - Form s={HI[30:0],LO[31]} and m=HI[31].
  - Issue sub with a=s, b=|rt|; borrow = (s < |rt|).
  - If m | ~borrow: HI<=alu_result, LO<={LO[30:0],1}.
  - Otherwise: HI<=s, LO<={LO[30:0],0}.
- FIX_LO:
  - Negate LO (sub, a=0, b=LO) when MULT has a negative product sign, or DIV has a negative quotient sign (sign(rs)^sign(rt)).
  - Otherwise issue add with b=0 (pass-through).
- FIX_HI:
  - MULT negate: add with a=~HI, b={31'b0, LO_before_fix==0}.
  - DIV with negative dividend: sub with a=0, b=HI.
  - Otherwise pass-through.
- alu_req=1 in ABS_A through FIX_HI only. Elsewhere alu_a=alu_b=0 and alu_ctrl=4'b0010.
- busy=1 from ABS_A through FIX_HI.
- Results:
  - DIV 0x8000_0000 / -1 yields LO=0x8000_0000, HI=0 (wraps, no trap).
  - Remainder takes the dividend's sign.

## Timing
- Accept edge is E0. States run ABS_A in cycle 1, ABS_B in cycle 2, ITER in cycles 3–34, FIX_LO in 35, FIX_HI in 36 and DONE in 37.
- done=1 in cycle 37 only. Latency is fixed at 37 cycles, independent of operands.
- Divide-by-zero: DONE in cycle 1, done=1 in cycle 1.
- hi/lo change only during ABS..FIX and hold after DONE until the next accept.
- Reset (rst_n=0 at an edge, including mid-operation):
  - state=IDLE; hi=lo=0; done=busy=div_by_zero=alu_req=0; start_ready=1.
  - Any in-flight result is discarded with no done pulse.
- start_valid while busy is ignored. Request inputs are sampled only at the accept edge.

## Structure
- Shared package muldiv_pkg holds:
  - ALU control constants: AND 0000, OR 0001, ADD 0010, SLL 0011, SRL 0100, SUB 0110, SLT 0111, SLTU 1011, NOR 1100.
  - op encodings.
  - the state enum.
- No sub-module. The ALU stays outside this block so the execute stage can share it (alu_req selects ownership at the top level).

## Test plan
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> done at cycle 37; HI=0xFFFFFFFE, LO=0x00000001; busy high cycles 1–36.
- MULT rs=-3, rt=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULT 0x80000000 × 0x80000000 -> HI=0x40000000, LO=0.
- DIV rs=-7, rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 0xFFFFFFFF / 0x10 -> LO=0x0FFFFFFF, HI=0xF.
- DIV rs=5, rt=0 -> done in cycle 1, HI=5, LO=0xFFFFFFFF, div_by_zero=1. DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
- rst_n low at cycle 20 of a DIVU -> next cycle busy=0, hi=lo=0; no done within 40 cycles; start_ready=1.
- Back-to-back: second request held at start_valid=1 is accepted in the DONE cycle (37). Its done arrives at cycle 74 with correct HI/LO. alu_req is never high in IDLE/DONE.
